ica_frame_loader: RTL and testbench

- Upstream feeder for the three-row dot-product stage (rows u[0], u[1], u[2] × 64 samples, 32-bit signed).
- Accepts one 3-channel whitened sample per cycle over a valid/ready stream and assembles 64-sample frames.
- Ping-pong double buffering lets the next frame fill while the consumer holds the current one.
- Presents a complete, stable frame array with a valid/ack handshake.

---
 rtl/ica_frame_loader.sv | 76 +++++++
 tb/tb_ica_frame_loader.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/ica_frame_loader.sv
// ica_frame_loader: ping-pong 3-channel frame assembler; in: s_valid/s_data0..2, m_ack; out: s_ready, m_valid, u, wr_idx, frame_cnt
module ica_frame_loader #(
  parameter int DW  = 32,
  parameter int N   = 64,
  parameter int CH  = 3,
  parameter int FCW = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DW-1:0]      s_data0,
  input  logic signed [DW-1:0]      s_data1,
  input  logic signed [DW-1:0]      s_data2,
  output logic                      m_valid,
  input  logic                      m_ack,
  output logic signed [DW-1:0]      u [0:CH-1][0:N-1],
  output logic [$clog2(N)-1:0]      wr_idx,
  output logic [FCW-1:0]            frame_cnt
);
  localparam int IW = $clog2(N);
  logic signed [DW-1:0] r_bank [0:1][0:CH-1][0:N-1];
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [1:0]           r_full;
  logic [IW-1:0]        r_wr_idx;
  logic [FCW-1:0]       r_frame_cnt;
  logic signed [DW-1:0] w_din [0:CH-1];
  logic                 w_acc;
  logic                 w_ack;
  assign w_din[0]  = s_data0;
  assign w_din[1]  = s_data1;
  assign w_din[2]  = s_data2;
  assign s_ready   = !r_full[r_wr_sel];
  assign m_valid   = r_full[r_rd_sel];
  assign w_acc     = s_valid & s_ready;
  assign w_ack     = m_ack & m_valid;
  assign wr_idx    = r_wr_idx;
  assign frame_cnt = r_frame_cnt;
  always_comb
    for (int k = 0; k < CH; k++)
      for (int i = 0; i < N; i++)
        u[k][i] = r_bank[r_rd_sel][k][i];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_full      <= 2'b00;
      r_wr_idx    <= '0;
      r_frame_cnt <= '0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < CH; k++)
          for (int i = 0; i < N; i++)
            r_bank[b][k][i] <= '0;
    end else begin
      if (w_acc) begin
        for (int k = 0; k < CH; k++)
          r_bank[r_wr_sel][k][r_wr_idx] <= w_din[k];
        if (r_wr_idx == IW'(N - 1)) begin
          r_full[r_wr_sel] <= 1'b1;
          r_wr_sel         <= ~r_wr_sel;
          r_wr_idx         <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      // accept needs the write bank empty and ack needs the read bank full,
      // so when both fire they touch different full bits
      if (w_ack) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
        r_frame_cnt      <= r_frame_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ica_frame_loader.sv
// tb_ica_frame_loader: directed table plus random scoreboard check of ica_frame_loader
module tb_ica_frame_loader;
  localparam int DW = 32, N = 64, CH = 3, FCW = 16, FR = 300;
  logic clk = 0, rst = 0, s_valid = 0, s_ready, m_valid, m_ack = 0;
  logic signed [DW-1:0] s_data0 = 0, s_data1 = 0, s_data2 = 0;
  logic signed [DW-1:0] u [0:CH-1][0:N-1];
  logic [$clog2(N)-1:0] wr_idx;
  logic [FCW-1:0] frame_cnt;
  int checks = 0, errors = 0, g = 0;

  ica_frame_loader #(.DW(DW), .N(N), .CH(CH), .FCW(FCW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data0(s_data0), .s_data1(s_data1), .s_data2(s_data2),
    .m_valid(m_valid), .m_ack(m_ack), .u(u), .wr_idx(wr_idx), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit rst, v, ack;
    int n;
    int rdy, val, idx, cnt, uk, ui, uv;
  } vec_t;
  typedef struct { int d [0:CH-1][0:N-1]; } frame_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input bit a);
    bit acc;
    rst = r; s_valid = v; m_ack = a;
    s_data0 = g; s_data1 = 1000 + g; s_data2 = 2000 + g;
    acc = v && s_ready && !r;
    @(posedge clk);
    #1;
    if (r) g = 0;
    else if (acc) g++;
  endtask

  vec_t tbl [14];
  frame_t q [$];
  frame_t cur;

  initial begin
    tbl[0]  = '{1,0,0, 1, 1,0,0,0,  0, 0,    0};
    tbl[1]  = '{0,1,0,63, 1,0,63,0, -1, 0,    0};
    tbl[2]  = '{0,1,0, 1, 1,1,0,0,  1, 5, 1005};
    tbl[3]  = '{0,0,0, 1, 1,1,0,0,  2,63, 2063};
    tbl[4]  = '{0,1,0,63, 1,1,63,0, 0, 0,    0};
    tbl[5]  = '{0,1,0, 1, 0,1,0,0,  0,63,   63};
    tbl[6]  = '{0,1,0, 3, 0,1,0,0,  0, 0,    0};
    tbl[7]  = '{0,1,1, 1, 1,1,0,1,  0, 0,   64};
    tbl[8]  = '{0,1,0, 1, 1,1,1,1,  2,63, 2127};
    tbl[9]  = '{0,1,0,62, 1,1,63,1, -1, 0,    0};
    tbl[10] = '{0,1,1, 1, 1,1,0,2,  0, 0,  128};
    tbl[11] = '{0,1,0,37, 1,1,37,2, 1, 0, 1128};
    tbl[12] = '{1,0,0, 1, 1,0,0,0,  2,63,    0};
    tbl[13] = '{0,0,1, 1, 1,0,0,0,  1, 5,    0};
    for (int r = 0; r < 14; r++) begin
      for (int c = 0; c < tbl[r].n; c++) step(tbl[r].rst, tbl[r].v, tbl[r].ack);
      chk($sformatf("row%0d s_ready", r), s_ready, tbl[r].rdy);
      chk($sformatf("row%0d m_valid", r), m_valid, tbl[r].val);
      chk($sformatf("row%0d wr_idx", r), wr_idx, tbl[r].idx);
      chk($sformatf("row%0d frame_cnt", r), frame_cnt, tbl[r].cnt);
      if (tbl[r].uk >= 0)
        chk($sformatf("row%0d u[%0d][%0d]", r, tbl[r].uk, tbl[r].ui), u[tbl[r].uk][tbl[r].ui], tbl[r].uv);
    end
    begin
      int nz = 0;
      for (int k = 0; k < CH; k++)
        for (int i = 0; i < N; i++)
          if (u[k][i] != 0) nz++;
      chk("reset u nonzero count", nz, 0);
    end
    s_valid = 0; m_ack = 0;
    begin
      int fill = 0, acked = 0, dly = -1, cyc = 0;
      int pend [0:CH-1];
      bit have = 0, v, a, acc;
      while (acked < FR && cyc < 90000) begin
        chk("rnd s_ready", s_ready, q.size() < 2);
        chk("rnd m_valid", m_valid, q.size() > 0);
        chk("rnd wr_idx", wr_idx, fill);
        if (q.size() > 0 && dly < 0) dly = $urandom_range(0, 100);
        a = q.size() > 0 && dly == 0;
        if (!have) begin
          for (int k = 0; k < CH; k++) pend[k] = $urandom;
          have = 1;
        end
        v = ($urandom % 2) == 1;
        s_valid = v; m_ack = a;
        s_data0 = pend[0]; s_data1 = pend[1]; s_data2 = pend[2];
        if (a) begin
          int bad = 0, bk = 0, bi = 0;
          for (int k = 0; k < CH; k++)
            for (int i = 0; i < N; i++)
              if (u[k][i] != q[0].d[k][i]) begin
                if (bad == 0) begin bk = k; bi = i; end
                bad++;
              end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL frame %0d: %0d words differ, u[%0d][%0d] got %0d expected %0d",
                     acked, bad, bk, bi, u[bk][bi], q[0].d[bk][bi]);
          end
        end
        acc = v && q.size() < 2;
        @(posedge clk);
        #1;
        cyc++;
        if (a) begin
          void'(q.pop_front());
          acked++;
          dly = -1;
        end else if (dly > 0) dly--;
        if (acc) begin
          for (int k = 0; k < CH; k++) cur.d[k][fill] = pend[k];
          have = 0;
          fill++;
          if (fill == N) begin
            q.push_back(cur);
            fill = 0;
          end
        end
      end
      s_valid = 0; m_ack = 0;
      if (cyc >= 90000) begin
        checks++;
        errors++;
        $display("FAIL random timeout: acked %0d expected %0d", acked, FR);
      end
      chk("rnd frame_cnt", frame_cnt, FR % 65536);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
